// File: rtl/odelaye3_asic_pkg.sv
// Shared types and constants for the ODELAYE3 replacement: tap width, parameter
// enums and the reset-tap conversion used at elaboration time.
package odelay_pkg;

  localparam int TAP_W   = 9;
  localparam int TAP_MAX = 511;

  typedef enum logic [1:0] {DT_FIXED, DT_VARIABLE, DT_VAR_LOAD} delay_type_e;
  typedef enum logic {DF_TIME, DF_COUNT} delay_format_e;
  typedef enum logic [1:0] {UM_ASYNC, UM_SYNC, UM_MANUAL} update_mode_e;
  typedef enum logic [1:0] {CS_NONE, CS_MASTER, CS_SLAVE_MIDDLE, CS_SLAVE_END} cascade_e;

  // TIME values are converted with integer division and saturate at the last tap.
  function automatic logic [TAP_W-1:0] reset_tap(delay_format_e fmt, int value, int tap_ps);
    int taps;
    if (fmt == DF_COUNT) taps = value;
    else if (tap_ps > 0) taps = value / tap_ps;
    else taps = 0;
    if (taps > TAP_MAX) taps = TAP_MAX;
    if (taps < 0) taps = 0;
    return taps[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/odelaye3_asic_if.sv
// Control, data and count signals of the output-delay block; the master side
// drives the controls and serializer data, the slave side is the delay block.
interface odelaye3_asic_if;
  import odelay_pkg::*;

  logic             CE;
  logic             INC;
  logic             LOAD;
  logic [TAP_W-1:0] CNTVALUEIN;
  logic             EN_VTC;
  logic             ODATAIN;
  logic             CASC_IN;
  logic             CASC_RETURN;
  logic             DATAOUT;
  logic             CASC_OUT;
  logic [TAP_W-1:0] CNTVALUEOUT;

  modport master (
    output CE, INC, LOAD, CNTVALUEIN, EN_VTC, ODATAIN, CASC_IN, CASC_RETURN,
    input  DATAOUT, CASC_OUT, CNTVALUEOUT
  );

  modport slave (
    input  CE, INC, LOAD, CNTVALUEIN, EN_VTC, ODATAIN, CASC_IN, CASC_RETURN,
    output DATAOUT, CASC_OUT, CNTVALUEOUT
  );

endinterface

// File: rtl/odelaye3_asic_tap_counter.sv
// 9-bit tap counter: reset tap on reset, then load or modulo-512 inc/dec as the
// delay type allows, frozen while VT compensation owns the counter.
module odelay_tap_counter
  import odelay_pkg::*;
#(
  parameter delay_type_e      DTYPE     = DT_FIXED,
  parameter logic [TAP_W-1:0] RESET_TAP = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             inc,
  input  logic             load,
  input  logic [TAP_W-1:0] cntvaluein,
  input  logic             en_vtc,
  output logic [TAP_W-1:0] cnt
);

  // Load outranks count enable; the natural 9-bit wrap gives 511+1=0 and 0-1=511.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RESET_TAP;
    end else if (!en_vtc) begin
      if (load && (DTYPE == DT_VAR_LOAD)) begin
        cnt <= cntvaluein;
      end else if (ce && (DTYPE != DT_FIXED)) begin
        cnt <= inc ? cnt + 9'd1 : cnt - 9'd1;
      end
    end
  end

endmodule

// File: rtl/odelaye3_asic.sv
// ASIC-portable ODELAYE3 stand-in: decodes the primitive's string parameters,
// keeps the tap count and routes data through the cascade path.
module odelaye3_asic
  import odelay_pkg::*;
#(
  parameter string DELAY_TYPE   = "FIXED",
  parameter string DELAY_FORMAT = "TIME",
  parameter int    DELAY_VALUE  = 0,
  parameter int    TAP_PS       = 5,
  parameter string UPDATE_MODE  = "ASYNC",
  parameter string CASCADE      = "NONE",
  parameter string SIM_DEVICE   = "ULTRASCALE"
) (
  input logic           CLK,
  input logic           RST,
  odelaye3_asic_if.slave bus
);

  localparam delay_type_e DTYPE =
    (DELAY_TYPE == "VARIABLE") ? DT_VARIABLE :
    (DELAY_TYPE == "VAR_LOAD") ? DT_VAR_LOAD : DT_FIXED;
  localparam delay_format_e DFMT = (DELAY_FORMAT == "COUNT") ? DF_COUNT : DF_TIME;
  localparam cascade_e CASC =
    (CASCADE == "MASTER")       ? CS_MASTER :
    (CASCADE == "SLAVE_MIDDLE") ? CS_SLAVE_MIDDLE :
    (CASCADE == "SLAVE_END")    ? CS_SLAVE_END : CS_NONE;
  localparam logic [TAP_W-1:0] RESET_TAP = reset_tap(DFMT, DELAY_VALUE, TAP_PS);

  if (!(DELAY_TYPE == "FIXED" || DELAY_TYPE == "VARIABLE" || DELAY_TYPE == "VAR_LOAD")) begin : g_bad_type
    $error("odelaye3_asic: illegal DELAY_TYPE %s", DELAY_TYPE);
  end
  if (!(DELAY_FORMAT == "TIME" || DELAY_FORMAT == "COUNT")) begin : g_bad_format
    $error("odelaye3_asic: illegal DELAY_FORMAT %s", DELAY_FORMAT);
  end
  if (!(UPDATE_MODE == "ASYNC" || UPDATE_MODE == "SYNC" || UPDATE_MODE == "MANUAL")) begin : g_bad_update
    $error("odelaye3_asic: illegal UPDATE_MODE %s", UPDATE_MODE);
  end
  if (!(CASCADE == "NONE" || CASCADE == "MASTER" || CASCADE == "SLAVE_MIDDLE" ||
        CASCADE == "SLAVE_END")) begin : g_bad_cascade
    $error("odelaye3_asic: illegal CASCADE %s", CASCADE);
  end
  if (DFMT == DF_COUNT && (DELAY_VALUE < 0 || DELAY_VALUE > TAP_MAX)) begin : g_bad_count
    $error("odelaye3_asic: DELAY_VALUE %0d outside tap range", DELAY_VALUE);
  end
  if (DFMT == DF_TIME && (TAP_PS <= 0 || DELAY_VALUE < 0)) begin : g_bad_time
    $error("odelaye3_asic: TIME format needs TAP_PS>0 and DELAY_VALUE>=0");
  end
  if (SIM_DEVICE == "") begin : g_bad_device
    $error("odelaye3_asic: SIM_DEVICE must not be empty");
  end

  odelay_tap_counter #(
    .DTYPE     (DTYPE),
    .RESET_TAP (RESET_TAP)
  ) u_tap_counter (
    .clk        (CLK),
    .rst        (RST),
    .ce         (bus.CE),
    .inc        (bus.INC),
    .load       (bus.LOAD),
    .cntvaluein (bus.CNTVALUEIN),
    .en_vtc     (bus.EN_VTC),
    .cnt        (bus.CNTVALUEOUT)
  );

  logic data_out;
  logic casc_out;

  // Pure routing: the pad cell supplies the physical delay, so no tap or clock here.
  always_comb begin
    data_out = bus.ODATAIN;
    casc_out = 1'b0;
    case (CASC)
      CS_MASTER: begin
        data_out = bus.CASC_RETURN;
        casc_out = bus.ODATAIN;
      end
      CS_SLAVE_MIDDLE: begin
        data_out = bus.CASC_RETURN;
        casc_out = bus.CASC_IN;
      end
      CS_SLAVE_END: begin
        data_out = bus.CASC_IN;
        casc_out = 1'b0;
      end
      default: begin
        data_out = bus.ODATAIN;
        casc_out = 1'b0;
      end
    endcase
  end

  assign bus.DATAOUT  = data_out;
  assign bus.CASC_OUT = casc_out;

endmodule

// File: tb/tb_odelaye3_asic.sv
// Drives six differently parameterised instances with shared stimulus and checks
// tap counts and routing against a queue of expected values.
module tb_odelaye3_asic;
  import odelay_pkg::*;

  localparam int N = 6;
  // Per instance: 0=FIXED 1=VARIABLE 2=VAR_LOAD; expected reset tap; 0=NONE 1=MASTER 2=SLAVE_MIDDLE 3=SLAVE_END
  localparam int TYPE_ARR[N] = '{2, 2, 2, 0, 1, 0};
  localparam int RTAP[N]     = '{0, 37, 100, 37, 10, 511};
  localparam int CASC_ARR[N] = '{0, 1, 2, 3, 0, 1};

  logic clk = 1'b0;
  logic rst, ce, inc, load, en_vtc, odatain, casc_in, casc_return;
  logic [TAP_W-1:0] cntin;
  logic [TAP_W-1:0] cnt_obs[N];
  logic dout_obs[N];
  logic cout_obs[N];

  int checks = 0;
  int failures = 0;
  int mc[N];

  typedef struct {
    string tag;
    int    idx;
    bit    is_data;
    int    exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  odelaye3_asic_if ifs[N] ();

  for (genvar g = 0; g < N; g++) begin : g_conn
    assign ifs[g].CE          = ce;
    assign ifs[g].INC         = inc;
    assign ifs[g].LOAD        = load;
    assign ifs[g].CNTVALUEIN  = cntin;
    assign ifs[g].EN_VTC      = en_vtc;
    assign ifs[g].ODATAIN     = odatain;
    assign ifs[g].CASC_IN     = casc_in;
    assign ifs[g].CASC_RETURN = casc_return;
    assign cnt_obs[g]         = ifs[g].CNTVALUEOUT;
    assign dout_obs[g]        = ifs[g].DATAOUT;
    assign cout_obs[g]        = ifs[g].CASC_OUT;
  end

  odelaye3_asic #(.DELAY_TYPE("VAR_LOAD"), .DELAY_FORMAT("COUNT"), .DELAY_VALUE(0),
                  .TAP_PS(5), .UPDATE_MODE("ASYNC"), .CASCADE("NONE"), .SIM_DEVICE("ULTRASCALE"))
    u0 (.CLK(clk), .RST(rst), .bus(ifs[0]));
  odelaye3_asic #(.DELAY_TYPE("VAR_LOAD"), .DELAY_FORMAT("COUNT"), .DELAY_VALUE(37),
                  .TAP_PS(5), .UPDATE_MODE("SYNC"), .CASCADE("MASTER"), .SIM_DEVICE("ULTRASCALE"))
    u1 (.CLK(clk), .RST(rst), .bus(ifs[1]));
  odelaye3_asic #(.DELAY_TYPE("VAR_LOAD"), .DELAY_FORMAT("TIME"), .DELAY_VALUE(500),
                  .TAP_PS(5), .UPDATE_MODE("MANUAL"), .CASCADE("SLAVE_MIDDLE"), .SIM_DEVICE("ULTRASCALE"))
    u2 (.CLK(clk), .RST(rst), .bus(ifs[2]));
  odelaye3_asic #(.DELAY_TYPE("FIXED"), .DELAY_FORMAT("COUNT"), .DELAY_VALUE(37),
                  .TAP_PS(5), .UPDATE_MODE("ASYNC"), .CASCADE("SLAVE_END"), .SIM_DEVICE("ULTRASCALE"))
    u3 (.CLK(clk), .RST(rst), .bus(ifs[3]));
  odelaye3_asic #(.DELAY_TYPE("VARIABLE"), .DELAY_FORMAT("COUNT"), .DELAY_VALUE(10),
                  .TAP_PS(5), .UPDATE_MODE("ASYNC"), .CASCADE("NONE"), .SIM_DEVICE("ULTRASCALE"))
    u4 (.CLK(clk), .RST(rst), .bus(ifs[4]));
  odelaye3_asic #(.DELAY_TYPE("FIXED"), .DELAY_FORMAT("TIME"), .DELAY_VALUE(5000),
                  .TAP_PS(5), .UPDATE_MODE("ASYNC"), .CASCADE("MASTER"), .SIM_DEVICE("ULTRASCALE"))
    u5 (.CLK(clk), .RST(rst), .bus(ifs[5]));

  function automatic int nextCnt(int k, int cur, bit r, bit l, bit c, bit i, bit e, int v);
    if (r) return RTAP[k];
    if (e) return cur;
    if (l && TYPE_ARR[k] == 2) return v;
    if (c && TYPE_ARR[k] != 0) return i ? (cur + 1) % 512 : (cur + 511) % 512;
    return cur;
  endfunction

  function automatic int expData(int k, bit o, bit ci, bit cr);
    case (CASC_ARR[k])
      1:       return {30'd0, cr, o};
      2:       return {30'd0, cr, ci};
      3:       return {30'd0, ci, 1'b0};
      default: return {30'd0, o, 1'b0};
    endcase
  endfunction

  task automatic applyStimulus(input bit r, input bit l, input bit c, input bit i,
                               input bit e, input int v, input string tag);
    rst = r; load = l; ce = c; inc = i; en_vtc = e; cntin = v[TAP_W-1:0];
    for (int k = 0; k < N; k++) begin
      mc[k] = nextCnt(k, mc[k], r, l, c, i, e, v);
      sb.push_back('{tag: tag, idx: k, is_data: 1'b0, exp: mc[k]});
    end
  endtask

  task automatic applyData(input bit o, input bit ci, input bit cr, input string tag);
    odatain = o; casc_in = ci; casc_return = cr;
    for (int k = 0; k < N; k++)
      sb.push_back('{tag: tag, idx: k, is_data: 1'b1, exp: expData(k, o, ci, cr)});
  endtask

  task automatic checkOutput(input bit clocked);
    exp_t e;
    int obs;
    if (clocked) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_data) obs = {30'd0, dout_obs[e.idx], cout_obs[e.idx]};
      else obs = {23'd0, cnt_obs[e.idx]};
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("[TB] FAIL %s u%0d: observed=%0d expected=%0d", e.tag, e.idx, obs, e.exp);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) mc[k] = 0;
    odatain = 1'b0; casc_in = 1'b0; casc_return = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, "reset0"); checkOutput(1);
    applyStimulus(1, 0, 0, 0, 0, 0, "reset1"); checkOutput(1);
    applyStimulus(1, 0, 0, 0, 0, 0, "reset2"); checkOutput(1);
    applyStimulus(0, 1, 1, 1, 0, 128, "load128"); checkOutput(1);
    applyStimulus(0, 1, 1, 1, 1, 200, "vtc_hold"); checkOutput(1);
    applyStimulus(0, 1, 0, 0, 0, 510, "load510"); checkOutput(1);
    applyStimulus(0, 0, 1, 1, 0, 0, "inc511"); checkOutput(1);
    applyStimulus(0, 0, 1, 1, 0, 0, "inc_wrap0"); checkOutput(1);
    applyStimulus(0, 0, 1, 1, 0, 0, "inc1"); checkOutput(1);
    applyStimulus(0, 0, 1, 0, 0, 0, "dec0"); checkOutput(1);
    applyStimulus(0, 0, 1, 0, 0, 0, "dec_wrap511"); checkOutput(1);
    applyStimulus(1, 1, 1, 1, 0, 200, "rst_priority"); checkOutput(1);
    applyStimulus(0, 0, 0, 0, 0, 0, "idle"); checkOutput(1);

    applyData(0, 0, 0, "data_o0"); checkOutput(0); #4;
    applyData(1, 0, 0, "data_o1"); checkOutput(0); #4;
    applyData(0, 0, 0, "data_o_fall"); checkOutput(0); #4;
    rst = 1'b1;
    for (int p = 1; p < 8; p++) begin
      applyData(p[2], p[1], p[0], "data_route"); checkOutput(0); #4;
    end
    rst = 1'b0;
    applyData(0, 0, 0, "data_final"); checkOutput(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
